// File: rtl/fifo_store_rd_stage.sv
// fifo_store_rd_stage: storage array plus a 2-entry read-side output buffer
// for the FIFO pointer manager.
// The array is written at the manager's write pointer and read combinationally
// at its read pointer. While the manager reports non-empty and the buffer has
// room, words are popped into the head/skid buffer and presented on a
// valid/ready interface.
// Optional feature macro: FIFO_PARITY_EN. When it is defined, every stored word
// carries an even-parity bit and parity_err flags a mismatch on the head word.
module fifo_store_rd_stage #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] wr_ptr,
   input  logic [$clog2(DEPTH)-1:0] rd_ptr,
   input  logic                     full,
   input  logic                     empty,
   output logic                     rd_en,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   input  logic                     out_ready,
   output logic [1:0]               out_occ,
   output logic                     parity_err
);

`ifdef FIFO_PARITY_EN
   localparam int SW = WIDTH + 1;
`else
   localparam int SW = WIDTH;
`endif

   // even parity of a data word
   function automatic logic calc_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   logic [SW-1:0] mem [DEPTH];
   logic [SW-1:0] wr_word;
   logic [SW-1:0] rd_word;
   logic [SW-1:0] head_r;
   logic [SW-1:0] skid_r;
   logic [SW-1:0] head_next;
   logic [SW-1:0] skid_next;
   logic [1:0]    occ_r;
   logic [1:0]    occ_next;
   logic          valid_r;
   logic          push;
   logic          pop;

`ifdef FIFO_PARITY_EN
   assign wr_word = {calc_parity(wr_data), wr_data};
`else
   assign wr_word = wr_data;
`endif

   // storage array write; a write while full is dropped, array is never reset
   always_ff @(posedge clk) begin
      if (wr_en && !full) begin
         mem[wr_ptr] <= wr_word;
      end
   end

   // array read is combinational at the manager's read pointer
   assign rd_word = mem[rd_ptr];

   // pop request uses only registered occupancy and empty, never out_ready
   assign rd_en = !empty && (occ_r < 2'd2);
   assign push  = rd_en;
   assign pop   = valid_r && out_ready;

   // next-state of the head/skid buffer, keeping FIFO order
   always_comb begin
      head_next = head_r;
      skid_next = skid_r;
      occ_next  = occ_r;
      case (occ_r)
         2'd0: begin
            if (push) begin
               head_next = rd_word;
               occ_next  = 2'd1;
            end else begin
               occ_next  = 2'd0;
            end
         end
         2'd1: begin
            case ({push, pop})
               2'b10: begin
                  skid_next = rd_word;
                  occ_next  = 2'd2;
               end
               2'b11: begin
                  head_next = rd_word;
                  occ_next  = 2'd1;
               end
               2'b01: begin
                  occ_next  = 2'd0;
               end
               default: begin
                  occ_next  = 2'd1;
               end
            endcase
         end
         2'd2: begin
            if (pop) begin
               head_next = skid_r;
               occ_next  = 2'd1;
            end else begin
               occ_next  = 2'd2;
            end
         end
         default: begin
            occ_next = 2'd0;
         end
      endcase
   end

   // buffer registers and registered valid; cleared by asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= '0;
         skid_r  <= '0;
         occ_r   <= 2'd0;
         valid_r <= 1'b0;
      end else begin
         head_r  <= head_next;
         skid_r  <= skid_next;
         occ_r   <= occ_next;
         valid_r <= (occ_next != 2'd0);
      end
   end

   assign out_valid = valid_r;
   assign out_data  = head_r[WIDTH-1:0];
   assign out_occ   = occ_r;

`ifdef FIFO_PARITY_EN
   assign parity_err = valid_r && (calc_parity(head_r[WIDTH-1:0]) != head_r[WIDTH]);
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_store_rd_stage.sv
// Testbench for fifo_store_rd_stage: a behavioural pointer manager drives the
// pointers/flags, a scoreboard queue holds accepted writes, and a negedge
// monitor checks every delivered word plus buffer occupancy against a
// word-count model of the stage.
module tb_fifo_store_rd_stage;
   localparam int DEPTH = 8;
   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic [2:0]       wr_ptr;
   logic [2:0]       rd_ptr;
   logic             full;
   logic             empty;
   logic             rd_en;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [1:0]       out_occ;
   logic             parity_err;

   logic [3:0]       mgr_cnt;
   logic [1:0]       model_occ;
   logic [WIDTH-1:0] exp_q[$];
   bit               flip_q[$];
   int               total;
   int               bad;
   int               delivered;

   fifo_store_rd_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .full(full), .empty(empty),
      .rd_en(rd_en), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .out_occ(out_occ), .parity_err(parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign full  = (mgr_cnt == 4'(DEPTH));
   assign empty = (mgr_cnt == 4'd0);

   // behavioural pointer manager
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= 3'd0;
         rd_ptr  <= 3'd0;
         mgr_cnt <= 4'd0;
      end else begin
         if (wr_en && !full) wr_ptr <= wr_ptr + 3'd1;
         if (rd_en) rd_ptr <= rd_ptr + 3'd1;
         mgr_cnt <= mgr_cnt + {3'd0, (wr_en && !full)} - {3'd0, rd_en};
      end
   end

   // word-count model of the stage: pull while the FIFO has data and room is left
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_occ <= 2'd0;
      end else begin
         model_occ <= model_occ + {1'b0, (!empty && model_occ < 2'd2)}
                                - {1'b0, (model_occ != 2'd0 && out_ready)};
      end
   end

   // scoreboard push on every accepted write
   always @(posedge clk) begin
      if (rst_n === 1'b1 && wr_en && !full) begin
         exp_q.push_back(wr_data);
         flip_q.push_back(1'b0);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitor: invariants every cycle, data/parity on every handshake
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("occ", 64'(out_occ), 64'(model_occ));
         chk("rd_en", 64'(rd_en), 64'(!empty && model_occ < 2'd2));
         chk("valid", 64'(out_valid), 64'(model_occ != 2'd0));
         if (out_valid) begin
            chk("parity_err", 64'(parity_err), 64'((flip_q.size() > 0) ? flip_q[0] : 1'b0));
         end else begin
            chk("parity_idle", 64'(parity_err), 64'(0));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(out_data), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
               chk("data", 64'(out_data), 64'(exp_q.pop_front()));
               void'(flip_q.pop_front());
               delivered++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      wr_en = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         step();
         n++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'(0));
      chk("drain_occ", 64'(out_occ), 64'(0));
   endtask

   initial begin
      int acc;
      int iter;
      total = 0;
      bad = 0;
      delivered = 0;
      rst_n = 1'b0;
      wr_en = 1'b0;
      wr_data = '0;
      out_ready = 1'b0;
      #2;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_occ", 64'(out_occ), 64'(0));
      chk("rst_rd_en", 64'(rd_en), 64'(0));
      chk("rst_data", 64'(out_data), 64'(0));
      chk("rst_perr", 64'(parity_err), 64'(0));
      step();
      step();
      rst_n = 1'b1;
      step();

      // single write latency
      wr_en = 1'b1;
      wr_data = 32'hA5A5_0001;
      step();
      wr_en = 1'b0;
      chk("lat_rd_en", 64'(rd_en), 64'(1));
      chk("lat_valid_early", 64'(out_valid), 64'(0));
      step();
      chk("lat_valid", 64'(out_valid), 64'(1));
      chk("lat_data", 64'(out_data), 64'h0000_0000_A5A5_0001);
      chk("lat_occ", 64'(out_occ), 64'(1));
      chk("lat_rd_en_low", 64'(rd_en), 64'(0));
      out_ready = 1'b1;
      step();
      chk("lat_pop_occ", 64'(out_occ), 64'(0));
      out_ready = 1'b0;

      // backpressure: 8 words with out_ready low
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1;
         wr_data = 32'(i);
         step();
      end
      wr_en = 1'b0;
      repeat (3) step();
      chk("bp_occ", 64'(out_occ), 64'(2));
      chk("bp_head", 64'(out_data), 64'(0));
      chk("bp_rd_en", 64'(rd_en), 64'(0));
      chk("bp_mgr_cnt", 64'(mgr_cnt), 64'(6));
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("bp_no_gap", 64'(out_valid), 64'(1));
         step();
      end
      drain();

      // streaming 20 words, pointers wrap
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1;
         wr_data = $urandom;
         step();
         if (i >= 2) chk("stream_rate", 64'(out_valid), 64'(1));
      end
      drain();

      // random write/ready traffic, 100 accepted words
      acc = 0;
      iter = 0;
      while (acc < 100 && iter < 5000) begin
         wr_en = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         wr_data = $urandom;
         if (wr_en && !full) acc++;
         step();
         iter++;
      end
      chk("rand_accepted", 64'(acc), 64'(100));
      drain();

`ifdef FIFO_PARITY_EN
      // corrupt a stored word before it leaves the array
      out_ready = 1'b0;
      wr_en = 1'b1;
      wr_data = 32'h0F0F_0003;
      step();
      wr_en = 1'b0;
      dut.mem[rd_ptr][0] = ~dut.mem[rd_ptr][0];
      exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] ^ 32'h0000_0001;
      flip_q[flip_q.size() - 1] = 1'b1;
      step();
      chk("par_flag", 64'(parity_err), 64'(1));
      chk("par_data", 64'(out_data), 64'h0000_0000_0F0F_0002);
      drain();
      wr_en = 1'b1;
      wr_data = 32'h0F0F_0007;
      step();
      wr_en = 1'b0;
      step();
      chk("par_clean", 64'(parity_err), 64'(0));
      drain();
`endif

      // asynchronous reset with a full stage and 3 words left in the FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1;
         wr_data = 32'h100 + 32'(i);
         step();
      end
      wr_en = 1'b0;
      step();
      chk("pre_rst_occ", 64'(out_occ), 64'(2));
      chk("pre_rst_cnt", 64'(mgr_cnt), 64'(3));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'(0));
      chk("arst_occ", 64'(out_occ), 64'(0));
      chk("arst_rd_en", 64'(rd_en), 64'(0));
      exp_q.delete();
      flip_q.delete();
      step();
      rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      wr_en = 1'b1;
      wr_data = 32'h0000_1234;
      delivered = 0;
      step();
      wr_en = 1'b0;
      drain();
      chk("post_rst_count", 64'(delivered), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global time bound so the run always terminates
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
